// File: rtl/cc_ben_unit.sv
// Condition-code / branch-enable unit with a LIFO save stack for CC across interrupt entry and RTI.
// Latency: CC, BEN and stack state all update 1 cycle after their load/push/pop strobe.
// No backpressure: illegal push/pop combinations are dropped and raise the sticky stack_err flag.
module cc_ben_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           bus,
  input  logic                       LDCC,
  input  logic [2:0]                 IR_in,
  input  logic                       LDBEN,
  input  logic                       cc_push,
  input  logic                       cc_pop,
  output logic                       BEN,
  output logic [2:0]                 CC,
  output logic [$clog2(DEPTH+1)-1:0] stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0] CC_Z = 3'b010;

  logic [2:0]    cc_q, cc_d;
  logic          ben_q, ben_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [2:0]    stack_q [DEPTH];
  logic [2:0]    stack_d [DEPTH];

  logic [2:0]    bus_nzp;
  logic          ben_calc;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Classify the bus value into a one-hot {N,Z,P} code.
  always_comb begin
    bus_nzp = CC_Z;
    if (bus[WIDTH-1]) begin
      bus_nzp = 3'b100;
    end else if (bus != '0) begin
      bus_nzp = 3'b001;
    end
  end

  assign ben_calc    = (IR_in[2] & cc_q[2]) | (IR_in[1] & cc_q[1]) | (IR_in[0] & cc_q[0]);
  assign stack_full  = (count_q == DEPTH_C);
  assign stack_empty = (count_q == '0);
  // Indices are only used when the matching push/pop is legal, so truncation at the ends is harmless.
  assign wr_idx      = IW'(count_q);
  assign rd_idx      = IW'(count_q - CW'(1));

  // Next-state for CC, BEN, stack pointer, stack contents and the sticky error flag.
  always_comb begin
    cc_d    = cc_q;
    count_d = count_q;
    err_d   = err_q;
    stack_d = stack_q;
    // BEN always evaluates against the CC held before this edge.
    ben_d   = LDBEN ? ben_calc : ben_q;

    if (cc_push && cc_pop) begin
      // Simultaneous push and pop is rejected outright; only the load is kept.
      err_d = 1'b1;
      if (LDCC) begin
        cc_d = bus_nzp;
      end
    end else if (cc_pop) begin
      // Pop owns the CC register this cycle, so LDCC is ignored either way.
      if (stack_empty) begin
        err_d = 1'b1;
      end else begin
        cc_d    = stack_q[rd_idx];
        count_d = count_q - CW'(1);
      end
    end else begin
      if (LDCC) begin
        cc_d = bus_nzp;
      end
      if (cc_push) begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          // The saved value is the CC before any same-cycle load.
          stack_d[wr_idx] = cc_q;
          count_d         = count_q + CW'(1);
        end
      end
    end
  end

  // Control state registers; synchronous reset wins over every strobe.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cc_q    <= CC_Z;
      ben_q   <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      ben_q   <= ben_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; contents are meaningless once the count is reset, so no reset here.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign CC          = cc_q;
  assign BEN         = ben_q;
  assign stack_count = count_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Self-checking bench for cc_ben_unit: table-driven vectors on a 16-bit/4-deep instance,
// plus a short hand-written sequence on an 8-bit instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_cc_ben_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 16-bit, 4-deep instance
  logic        a_rst, a_ldcc, a_ldben, a_push, a_pop;
  logic [15:0] a_bus;
  logic [2:0]  a_ir;
  logic        a_ben, a_full, a_empty, a_err;
  logic [2:0]  a_cc;
  logic [2:0]  a_cnt;

  cc_ben_unit #(.WIDTH(16), .DEPTH(4)) u_a (
    .clk(clk), .Reset(a_rst), .bus(a_bus), .LDCC(a_ldcc), .IR_in(a_ir), .LDBEN(a_ldben),
    .cc_push(a_push), .cc_pop(a_pop), .BEN(a_ben), .CC(a_cc), .stack_count(a_cnt),
    .stack_full(a_full), .stack_empty(a_empty), .stack_err(a_err)
  );

  // 8-bit, 4-deep instance
  logic        b_rst, b_ldcc, b_ldben, b_push, b_pop;
  logic [7:0]  b_bus;
  logic [2:0]  b_ir;
  logic        b_ben, b_full, b_empty, b_err;
  logic [2:0]  b_cc;
  logic [2:0]  b_cnt;

  cc_ben_unit #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .Reset(b_rst), .bus(b_bus), .LDCC(b_ldcc), .IR_in(b_ir), .LDBEN(b_ldben),
    .cc_push(b_push), .cc_pop(b_pop), .BEN(b_ben), .CC(b_cc), .stack_count(b_cnt),
    .stack_full(b_full), .stack_empty(b_empty), .stack_err(b_err)
  );

  typedef struct {
    logic        rst;
    logic [15:0] bus;
    logic        ldcc;
    logic [2:0]  ir;
    logic        ldben;
    logic        push;
    logic        pop;
    logic [2:0]  e_cc;
    logic        e_ben;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [15:0] bus, input logic ldcc,
                              input logic [2:0] ir, input logic ldben, input logic push,
                              input logic pop, input logic [2:0] e_cc, input logic e_ben,
                              input logic [2:0] e_cnt, input logic e_err);
    vec_t v;
    v.rst = rst; v.bus = bus; v.ldcc = ldcc; v.ir = ir; v.ldben = ldben;
    v.push = push; v.pop = pop; v.e_cc = e_cc; v.e_ben = e_ben; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  // Packed observation: {cc, ben, count, full, empty, err}
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got cc/ben/cnt/full/empty/err=%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
               name, act[9:7], act[6], act[5:3], act[2], act[1], act[0],
               exp[9:7], exp[6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [9:0] expect_vec(input logic [2:0] cc, input logic ben,
                                            input logic [2:0] cnt, input logic err);
    return {cc, ben, cnt, (cnt == 3'd4), (cnt == 3'd0), err};
  endfunction

  task automatic b_step(input logic rst, input logic [7:0] bus, input logic ldcc,
                        input logic [2:0] ir, input logic ldben, input logic push, input logic pop);
    b_rst = rst; b_bus = bus; b_ldcc = ldcc; b_ir = ir; b_ldben = ldben; b_push = push; b_pop = pop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_bus = '0; a_ldcc = 1'b0; a_ir = '0; a_ldben = 1'b0; a_push = 1'b0; a_pop = 1'b0;
    b_rst = 1'b1; b_bus = '0; b_ldcc = 1'b0; b_ir = '0; b_ldben = 1'b0; b_push = 1'b0; b_pop = 1'b0;

    //                rst bus       ldcc ir     ldben push pop   cc     ben cnt err
    vq.push_back(mk(1, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0)); // 0 reset
    vq.push_back(mk(0, 16'h0000, 1, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0)); // 1 zero
    vq.push_back(mk(0, 16'h7FFF, 1, 3'b000, 0, 0, 0, 3'b001, 0, 0, 0)); // 2 max positive
    vq.push_back(mk(0, 16'h8000, 1, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0)); // 3 min negative
    vq.push_back(mk(0, 16'h0000, 0, 3'b100, 1, 0, 0, 3'b100, 1, 0, 0)); // 4 n match
    vq.push_back(mk(0, 16'h0000, 0, 3'b011, 1, 0, 0, 3'b100, 0, 0, 0)); // 5 zp vs N
    vq.push_back(mk(0, 16'h0000, 0, 3'b111, 1, 0, 0, 3'b100, 1, 0, 0)); // 6 nzp on N
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 1, 0, 0, 3'b100, 0, 0, 0)); // 7 clear BEN
    vq.push_back(mk(0, 16'h0000, 1, 3'b111, 1, 0, 0, 3'b010, 1, 0, 0)); // 8 nzp old N
    vq.push_back(mk(0, 16'h0001, 1, 3'b000, 1, 0, 0, 3'b001, 0, 0, 0)); // 9 clear BEN
    vq.push_back(mk(0, 16'h0000, 0, 3'b111, 1, 0, 0, 3'b001, 1, 0, 0)); // 10 nzp on P
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 1, 0, 0, 3'b001, 0, 0, 0)); // 11 clear BEN
    vq.push_back(mk(0, 16'h0000, 1, 3'b001, 1, 0, 0, 3'b010, 1, 0, 0)); // 12 old P used
    vq.push_back(mk(0, 16'h0001, 1, 3'b000, 0, 0, 0, 3'b001, 1, 0, 0)); // 13 BEN holds
    vq.push_back(mk(0, 16'h0000, 1, 3'b010, 1, 0, 0, 3'b010, 0, 0, 0)); // 14 new Z not used
    vq.push_back(mk(0, 16'h0001, 1, 3'b000, 0, 0, 0, 3'b001, 0, 0, 0)); // 15
    vq.push_back(mk(0, 16'h8000, 1, 3'b000, 0, 1, 0, 3'b100, 0, 1, 0)); // 16 push 001
    vq.push_back(mk(0, 16'h0000, 1, 3'b000, 0, 1, 0, 3'b010, 0, 2, 0)); // 17 push 100
    vq.push_back(mk(0, 16'h0001, 1, 3'b000, 0, 1, 0, 3'b001, 0, 3, 0)); // 18 push 010
    vq.push_back(mk(0, 16'h8000, 1, 3'b000, 0, 1, 0, 3'b100, 0, 4, 0)); // 19 push 001, full
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 1, 0, 3'b100, 0, 4, 1)); // 20 overflow
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 0, 1, 3'b001, 0, 3, 1)); // 21 pop
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 0, 1, 3'b010, 0, 2, 1)); // 22 pop
    vq.push_back(mk(0, 16'hFFFF, 1, 3'b000, 0, 0, 1, 3'b100, 0, 1, 1)); // 23 pop beats LDCC
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 0, 1, 3'b001, 0, 0, 1)); // 24 pop to empty
    vq.push_back(mk(0, 16'h0000, 0, 3'b111, 1, 1, 0, 3'b001, 1, 1, 1)); // 25 push, BEN=1
    vq.push_back(mk(1, 16'h8000, 1, 3'b111, 1, 1, 0, 3'b010, 0, 0, 0)); // 26 reset priority
    vq.push_back(mk(0, 16'h8000, 1, 3'b000, 0, 0, 1, 3'b010, 0, 0, 1)); // 27 underflow
    vq.push_back(mk(1, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0)); // 28 reset
    vq.push_back(mk(0, 16'h0001, 1, 3'b000, 0, 1, 0, 3'b001, 0, 1, 0)); // 29 push 010
    vq.push_back(mk(0, 16'hFFFF, 1, 3'b000, 0, 1, 1, 3'b100, 0, 1, 1)); // 30 push+pop
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 0, 1, 3'b010, 0, 0, 1)); // 31 entry intact
    vq.push_back(mk(1, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0)); // 32 reset
    vq.push_back(mk(0, 16'h0000, 0, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0)); // 33 idle

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      a_rst = vq[i].rst; a_bus = vq[i].bus; a_ldcc = vq[i].ldcc; a_ir = vq[i].ir;
      a_ldben = vq[i].ldben; a_push = vq[i].push; a_pop = vq[i].pop;
      @(posedge clk);
      #1;
      check($sformatf("a_vec%0d", i), {a_cc, a_ben, a_cnt, a_full, a_empty, a_err},
            expect_vec(vq[i].e_cc, vq[i].e_ben, vq[i].e_cnt, vq[i].e_err));
    end

    // 8-bit instance: sign bit at bit 7, and pop overriding a same-cycle load.
    b_step(1, 8'h00, 0, 3'b000, 0, 0, 0);
    check("b_reset", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b010, 0, 0, 0));
    b_step(0, 8'h80, 1, 3'b000, 0, 0, 0);
    check("b_neg80", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b100, 0, 0, 0));
    b_step(0, 8'h01, 1, 3'b000, 0, 0, 0);
    check("b_pos01", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b001, 0, 0, 0));
    b_step(0, 8'h7F, 1, 3'b000, 0, 1, 0);
    check("b_push", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b001, 0, 1, 0));
    b_step(0, 8'h00, 1, 3'b000, 0, 0, 0);
    check("b_zero", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b010, 0, 1, 0));
    b_step(0, 8'hFF, 1, 3'b100, 1, 0, 1);
    check("b_pop_ldcc", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b001, 0, 0, 0));
    b_step(0, 8'h00, 0, 3'b001, 1, 0, 0);
    check("b_ben_p", {b_cc, b_ben, b_cnt, b_full, b_empty, b_err}, expect_vec(3'b001, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_ben_unit.md
Name: cc_ben_unit

Overview:
Parametrised successor to the LC-3 condition-code/branch-enable logic. Derives N/Z/P from a WIDTH-bit bus value, holds the registered condition codes, and computes BEN from IR[11:9]. Adds a DEPTH-entry hardware stack so the control FSM can save and restore condition codes across interrupt entry and RTI. Sits beside the datapath bus and feeds BEN and CC to the control FSM and the PSR.

Parameters:
WIDTH, 16, bus width in bits; sign bit is bus[WIDTH-1]; legal range is WIDTH >= 2.
DEPTH, 4, number of CC save-stack entries; legal range is DEPTH >= 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
bus  in  WIDTH  datapath bus value to classify
LDCC  in  1  load N/Z/P from the classification of bus
IR_in  in  3  IR[11:9], the n/z/p branch mask
LDBEN  in  1  load BEN
cc_push  in  1  push current registered CC onto the save stack
cc_pop  in  1  pop the top stack entry into the CC register
BEN  out  1  registered branch enable
CC  out  3  registered {N,Z,P}
stack_count  out  $clog2(DEPTH+1)  number of valid stack entries
stack_full  out  1  stack_count == DEPTH (combinational from count)
stack_empty  out  1  stack_count == 0 (combinational from count)
stack_err  out  1  sticky error flag

Behaviour:
- Reset, synchronous with priority over everything: CC=3'b010 (Z), BEN=0, stack_count=0, stack_err=0. Stack contents are don't-care.
- Classification, combinational from bus:
  - bus == 0 -> 010.
  - bus[WIDTH-1] == 0 and bus != 0 -> 001.
  - bus[WIDTH-1] == 1 -> 100.
  - Exactly one bit is ever set.
- BEN logic: (IR_in[2]&N)|(IR_in[1]&Z)|(IR_in[0]&P), using the registered CC value before any same-cycle update.
  - With LDBEN=1, BEN takes this value at the next edge; otherwise BEN holds.
  - Latency: 1 cycle from LDBEN.
- LDCC=1 (no pop): CC takes the classification at the next edge. Latency is 1 cycle.
- cc_push=1, cc_pop=0:
  - Not full: write the registered CC, as it was before this edge, to entry[stack_count]; count+1.
  - LDCC in the same cycle still updates CC, and the pushed value is the old CC.
  - Full: no write, count unchanged, stack_err<=1.
- cc_pop=1, cc_push=0:
  - Not empty: CC <= entry[stack_count-1]; count-1. Pop has priority over LDCC in the same cycle, so LDCC is ignored.
  - Empty: CC unchanged (LDCC also ignored), count unchanged, stack_err<=1.
- cc_push=1 and cc_pop=1 together: illegal. Stack and count unchanged, pop not performed, stack_err<=1. LDCC is still honoured.
- LDBEN in the same cycle as a pop or LDCC evaluates on the old CC.
- stack_err is sticky; only Reset clears it.
- Reset mid-sequence discards all stacked entries; no partial state survives.
- The stack is LIFO with no wrap-around; the count is saturating-checked as above and never wraps.

Test Plan:
1. Reset, then LDCC with bus=16'h0000, then 16'h7FFF, then 16'h8000 -> CC reads 010, 001, 100 one cycle after each load; BEN=0 after reset.
2. CC=100, IR_in=3'b100, LDBEN -> BEN=1 next cycle. IR_in=3'b011, LDBEN -> BEN=0. IR_in=3'b111 -> BEN=1 for every CC value.
3. Same cycle: LDCC with bus=0 and LDBEN with IR_in=3'b001, starting from CC=001 -> BEN=1 (old CC used) and CC=010.
4. DEPTH=4: push with CC=001, 100, 010, 001 -> count=4, full=1. A 5th push -> count stays 4, stack_err=1. Four pops -> CC=001, 010, 100, 001 in order, empty=1.
5. Pop on empty -> CC unchanged, stack_err=1. Push+pop together with LDCC bus=16'hFFFF -> count unchanged, CC=100, stack_err=1. Reset -> stack_err=0, count=0, CC=010.
6. WIDTH=8 instance: bus=8'h80 -> 100; bus=8'h01 -> 001. Pop and LDCC in the same cycle -> CC equals the popped value.
